sys_mem_responder: RTL and testbench
====================================

// Module: sys_mem_responder
// PURPOSE
//  Responder (slave) end of the SysMem cache-line protocol. It accepts one request at a time from the
//  cache arbiter, which drives sysmem_bus as master. Each request is a full cache-line read or write to an
//  internal line array. It returns an acknowledge after a programmable latency. Used as the system memory
//  model / on-chip RAM behind the L1 arbiter.
// PARAMETERS
//  CL_LEN     32          bytes per cache line; must be a power of 2
//  PC_SZ      32          address width in bits
//  MEM_LINES  1024        number of cache lines stored; must be a power of 2
//  BASE_ADDR  32'h0       byte address of line 0 (Phys_Addr_Lo)
//  LATENCY    4           wait cycles between request accept and ack_valid; range 0..255
// PORTS
//  clk_in                   in   1           clock; all logic on posedge
//  reset_in                 in   1           asynchronous, active-low reset
//  sysmem_bus               SysMem.slave     interface; its members are listed below
//   .req_valid              in   1           request present
//   .req_rdy                out  1           responder can accept a request
//   .req_rw                 in   1           1 = read, 0 = write
//   .req_addr               in   PC_SZ       byte address; the low log2(CL_LEN) bits are ignored
//   .req_wr_data            in   CL_LEN*8    write line data; used only when req_rw==0
//   .ack_valid              out  1           response present
//   .ack_rdy                in   1           master accepts the response
//   .ack_rd_data            out  CL_LEN*8    read line data; '0 on a write acknowledge
//  addr_err_out             out  1           1-cycle pulse when an accepted request is out of range
// BEHAVIOUR
//  Reset (reset_in==0, asynchronous)
//   - state=IDLE; req_rdy=0 while reset is asserted, then 1 in IDLE; ack_valid=0; ack_rd_data='0.
//   - addr_err_out=0; latency counter=0.
//   - Line array contents are not cleared.
//   - Reset mid-operation aborts the transaction. A write not yet committed is discarded.
//  State machine: IDLE -> WAIT -> ACK -> IDLE
//   - IDLE: req_rdy=1.
//     - On req_valid&&req_rdy, latch rw, line index and wr_data, and load the counter with LATENCY.
//     - Next state is WAIT, or ACK directly when LATENCY==0.
//   - WAIT: req_rdy=0. The counter decrements each cycle; at count 1 the next state is ACK.
//     - Total accept-to-ack_valid latency = LATENCY+1 cycles. With LATENCY==0 it is 1 cycle.
//   - Commit on the transition into ACK, all on the same clock edge:
//     - write: array[idx] <= wr_data.
//     - read: ack_rd_data <= array[idx].
//   - ACK: ack_valid=1 and ack_rd_data is registered.
//     - Hold ack_valid and ack_rd_data stable until ack_rdy.
//     - On ack_valid&&ack_rdy, go to IDLE. ack_valid drops the next cycle and ack_rd_data returns to '0.
//   - No request is accepted in WAIT or ACK. The earliest back-to-back accept is the cycle after the ack
//     handshake.
//  Addressing
//   - off = req_addr - BASE_ADDR, computed modulo 2^PC_SZ.
//   - idx = off >> log2(CL_LEN).
//   - In range when idx < MEM_LINES.
//  Out-of-range request (this includes req_addr < BASE_ADDR, which wraps to a large off)
//   - Still accepted and still acknowledged with normal timing.
//   - A write is dropped. A read returns '0.
//   - addr_err_out pulses for 1 cycle, in the cycle after the accept.
//  Read-after-write to the same line returns the new data, because the write commits before the next accept.
//  Misaligned req_addr: the low bits are ignored and the whole line is accessed.
//  req_wr_data is ignored for reads.
// STRUCTURE
//  Shared package (cpu_params_pkg): CL_LEN and PC_SZ are already there. Add:
//   - MEM_LINES, SYSMEM_BASE and SYSMEM_LATENCY defaults
//   - typedef line_t = logic [CL_LEN*8-1:0]
//  Sub-module sysmem_line_ram: one write port and one read port, both synchronous.
//   - Ports: clk_in, we, widx, wdata, re, ridx, rdata. No reset.
//   - The FSM, counter and address-decode logic stay in sys_mem_responder.
// TESTING
//  1 Reset then idle: hold reset_in=0 for 3 clks, release -> req_rdy=1, ack_valid=0, addr_err_out=0.
//  2 Write then read, LATENCY=4:
//    - Write BASE+0x40 with data = 32 bytes 0x00..0x1F -> ack_valid rises 5 clks after accept.
//    - Read BASE+0x40 -> ack_rd_data == 0x1F1E..0100.
//  3 Backpressure: hold ack_rdy=0 for 10 clks during ACK -> ack_valid and ack_rd_data stable, req_rdy=0.
//    Raise ack_rdy -> IDLE on the next clk.
//  4 LATENCY=0, read at BASE+0x7FE0 (line 1023) with req_addr low bits = 0x1F
//    -> ack_valid 1 clk after accept; the line 1023 contents are returned.
//  5 Out of range:
//    - Write BASE+0x8000 (idx=1024) -> acked, addr_err_out pulse, no array line changed.
//    - Read BASE-0x20 -> '0 returned with addr_err_out pulse.
//  6 Reset mid-write: assert reset_in in WAIT (count=2) -> ack_valid=0 immediately.
//    After release, reading that line returns its old data.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Shared CPU/memory-system parameters and types. The SysMem responder takes its
// defaults and its FSM state type from here.
package cpu_params_pkg;

  localparam int CL_LEN = 32;
  localparam int PC_SZ  = 32;

  localparam int               MEM_LINES      = 1024;
  localparam logic [PC_SZ-1:0] SYSMEM_BASE    = '0;
  localparam int               SYSMEM_LATENCY = 4;

  typedef logic [CL_LEN*8-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } sysmem_state_t;

endpackage

// File: rtl/sys_mem_responder_if.sv
// SysMem cache-line bus: one request channel (master -> responder) and one
// acknowledge channel (responder -> master), each with a valid/ready pair.
interface sys_mem_responder_if #(
  parameter int CL_LEN = cpu_params_pkg::CL_LEN,
  parameter int PC_SZ  = cpu_params_pkg::PC_SZ
);

  logic                  req_valid;
  logic                  req_rdy;
  logic                  req_rw;
  logic [PC_SZ-1:0]      req_addr;
  logic [CL_LEN*8-1:0]   req_wr_data;
  logic                  ack_valid;
  logic                  ack_rdy;
  logic [CL_LEN*8-1:0]   ack_rd_data;

  modport master (
    output req_valid, req_rw, req_addr, req_wr_data, ack_rdy,
    input  req_rdy, ack_valid, ack_rd_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wr_data, ack_rdy,
    output req_rdy, ack_valid, ack_rd_data
  );

endinterface

// File: rtl/sysmem_line_ram.sv
// Cache-line storage: one synchronous write port and one synchronous read port.
module sysmem_line_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 256
) (
  input  logic                     clk_in,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; contents must survive
  // a reset pulse, and a reset port would keep this from mapping onto block RAM.
  always_ff @(posedge clk_in) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/sys_mem_responder.sv
// SysMem responder: accepts one cache-line read/write at a time, commits it to
// the line array after LATENCY wait cycles, then holds the ack until taken.
module sys_mem_responder #(
  parameter int               CL_LEN    = cpu_params_pkg::CL_LEN,
  parameter int               PC_SZ     = cpu_params_pkg::PC_SZ,
  parameter int               MEM_LINES = cpu_params_pkg::MEM_LINES,
  parameter logic [PC_SZ-1:0] BASE_ADDR = cpu_params_pkg::SYSMEM_BASE,
  parameter int               LATENCY   = cpu_params_pkg::SYSMEM_LATENCY
) (
  input  logic                clk_in,
  input  logic                reset_in,
  sys_mem_responder_if.slave  sysmem_bus,
  output logic                addr_err_out
);

  import cpu_params_pkg::sysmem_state_t, cpu_params_pkg::ST_IDLE,
         cpu_params_pkg::ST_WAIT, cpu_params_pkg::ST_ACK;

  localparam int         OFF_LSB = $clog2(CL_LEN);
  localparam int         IDX_W   = $clog2(MEM_LINES);
  localparam int         LW      = CL_LEN * 8;
  localparam logic [7:0] LAT     = 8'(LATENCY);

  sysmem_state_t    state_q, state_d;
  logic [7:0]       cnt_q;
  logic             rw_q, oor_q, err_q, rd_ok_q;
  logic [IDX_W-1:0] idx_q;
  logic [LW-1:0]    wdata_q, rdata;

  logic [PC_SZ-1:0] off, line_no;
  logic             in_range, accept, ack_done, commit;
  logic             cm_rw, cm_oor;
  logic [IDX_W-1:0] cm_idx;
  logic [LW-1:0]    cm_wdata;

  // Offset wraps modulo 2^PC_SZ, so addresses below BASE_ADDR land out of range.
  always_comb begin
    off      = sysmem_bus.req_addr - BASE_ADDR;
    line_no  = off >> OFF_LSB;
    in_range = line_no < PC_SZ'(MEM_LINES);
  end

  assign accept   = (state_q == ST_IDLE) && sysmem_bus.req_valid;
  assign ack_done = (state_q == ST_ACK) && sysmem_bus.ack_rdy;
  assign commit   = (accept && (LATENCY == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 8'd1));

  // With zero latency the commit happens on the accept edge, before the request
  // has been latched, so the commit operands bypass the holding registers.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cm_rw    = sysmem_bus.req_rw;
      cm_oor   = !in_range;
      cm_idx   = line_no[IDX_W-1:0];
      cm_wdata = sysmem_bus.req_wr_data;
    end else begin
      cm_rw    = rw_q;
      cm_oor   = oor_q;
      cm_idx   = idx_q;
      cm_wdata = wdata_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)     state_d = (LATENCY == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (commit)     state_d = ST_ACK;
      ST_ACK:  if (ack_done)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sysmem_bus.req_rdy     = (state_q == ST_IDLE) && reset_in;
    sysmem_bus.ack_valid   = (state_q == ST_ACK);
    sysmem_bus.ack_rd_data = rd_ok_q ? rdata : '0;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      if (accept) begin
        rw_q  <= sysmem_bus.req_rw;
        oor_q <= !in_range;
        idx_q <= line_no[IDX_W-1:0];
        cnt_q <= LAT;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (commit)        rd_ok_q <= cm_rw && !cm_oor;
      else if (ack_done) rd_ok_q <= 1'b0;
    end
  end

  // Write data is only consumed at commit, which a reset always precedes or cancels.
  always_ff @(posedge clk_in) begin
    if (accept) wdata_q <= sysmem_bus.req_wr_data;
  end

  sysmem_line_ram #(
    .DEPTH (MEM_LINES),
    .WIDTH (LW)
  ) u_ram (
    .clk_in (clk_in),
    .we     (commit && !cm_rw && !cm_oor),
    .widx   (cm_idx),
    .wdata  (cm_wdata),
    .re     (commit && cm_rw && !cm_oor),
    .ridx   (cm_idx),
    .rdata  (rdata)
  );

  assign addr_err_out = err_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Bench for sys_mem_responder: two responders (LATENCY 4 and 0) checked each
// cycle against a transaction-level model, plus directed literal expectations.
module tb_sys_mem_responder;
  import cpu_params_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT_A = 4;
  localparam int          LAT_B = 0;
  localparam logic [31:0] SPAN  = 32'h0000_8000;  // 1024 lines * 32 bytes

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sys_mem_responder_if #(.CL_LEN(CL_LEN), .PC_SZ(PC_SZ)) bus_a ();
  sys_mem_responder_if #(.CL_LEN(CL_LEN), .PC_SZ(PC_SZ)) bus_b ();
  logic err_a, err_b;

  sys_mem_responder #(.BASE_ADDR(BASE), .LATENCY(LAT_A)) u_a (
    .clk_in(clk), .reset_in(rst_n), .sysmem_bus(bus_a), .addr_err_out(err_a));
  sys_mem_responder #(.BASE_ADDR(BASE), .LATENCY(LAT_B)) u_b (
    .clk_in(clk), .reset_in(rst_n), .sysmem_bus(bus_b), .addr_err_out(err_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- accessors ----------------
  function automatic logic   in_valid(input int i);   return i == 0 ? bus_a.req_valid   : bus_b.req_valid;   endfunction
  function automatic logic   in_rw(input int i);      return i == 0 ? bus_a.req_rw      : bus_b.req_rw;      endfunction
  function automatic logic [31:0] in_addr(input int i); return i == 0 ? bus_a.req_addr  : bus_b.req_addr;    endfunction
  function automatic line_t  in_wd(input int i);      return i == 0 ? bus_a.req_wr_data : bus_b.req_wr_data; endfunction
  function automatic logic   in_ack_rdy(input int i); return i == 0 ? bus_a.ack_rdy     : bus_b.ack_rdy;     endfunction
  function automatic logic   out_rdy(input int i);    return i == 0 ? bus_a.req_rdy     : bus_b.req_rdy;     endfunction
  function automatic logic   out_ack(input int i);    return i == 0 ? bus_a.ack_valid   : bus_b.ack_valid;   endfunction
  function automatic line_t  out_data(input int i);   return i == 0 ? bus_a.ack_rd_data : bus_b.ack_rd_data; endfunction
  function automatic logic   out_err(input int i);    return i == 0 ? err_a             : err_b;             endfunction
  function automatic int     lat_of(input int i);     return i == 0 ? LAT_A             : LAT_B;             endfunction

  function automatic line_t mkpat(input logic [31:0] seed);
    line_t p;
    for (int k = 0; k < 8; k++) p[32*k +: 32] = seed + 32'(k) * 32'h0101_0101;
    return p;
  endfunction

  // ---------------- transaction model ----------------
  int    cyc = 0;
  bit    m_busy[2], m_ack[2], m_rd[2], m_oor[2], m_err[2], m_acc[2], m_known[2];
  int    m_key[2], m_due[2];
  line_t m_wd[2], m_rv[2];
  line_t model_mem[int];
  int    t_acc[2];
  logic  last_err[2];

  initial forever begin
    logic [31:0] off;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_ack[i] = 0; m_err[i] = 0; m_acc[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        m_err[i] = 0;
        m_acc[i] = 0;
        if (m_ack[i]) begin
          if (in_ack_rdy(i)) begin
            m_ack[i]  = 0;
            m_busy[i] = 0;
          end
        end else if (!m_busy[i] && in_valid(i)) begin
          off       = in_addr(i) - BASE;
          m_oor[i]  = off >= SPAN;
          m_key[i]  = i * 4096 + int'(off / 32);
          m_rd[i]   = in_rw(i);
          m_wd[i]   = in_wd(i);
          m_busy[i] = 1;
          m_acc[i]  = 1;
          m_err[i]  = m_oor[i];
          m_due[i]  = cyc + lat_of(i);
        end
        if (m_busy[i] && !m_ack[i] && cyc == m_due[i]) begin
          m_rv[i]    = '0;
          m_known[i] = 1;
          if (!m_oor[i]) begin
            if (!m_rd[i]) model_mem[m_key[i]] = m_wd[i];
            else if (model_mem.exists(m_key[i])) m_rv[i] = model_mem[m_key[i]];
            else m_known[i] = 0;
          end
          m_ack[i] = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("req_rdy[%0d]", i),   out_rdy(i), rst_n && !m_busy[i]);
      check($sformatf("ack_valid[%0d]", i), out_ack(i), m_ack[i]);
      check($sformatf("addr_err[%0d]", i),  out_err(i), m_err[i]);
      if (!m_ack[i] || m_known[i])
        check($sformatf("ack_rd_data[%0d]", i), out_data(i), m_ack[i] ? m_rv[i] : '0);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic set_req(input int i, input logic v, input logic rw,
                         input logic [31:0] a, input line_t d);
    if (i == 0) begin
      bus_a.req_valid = v; bus_a.req_rw = rw; bus_a.req_addr = a; bus_a.req_wr_data = d;
    end else begin
      bus_b.req_valid = v; bus_b.req_rw = rw; bus_b.req_addr = a; bus_b.req_wr_data = d;
    end
  endtask

  task automatic set_ack_rdy(input int i, input logic v);
    if (i == 0) bus_a.ack_rdy = v;
    else        bus_b.ack_rdy = v;
  endtask

  task automatic issue(input int i, input logic rw, input logic [31:0] a, input line_t d);
    int n;
    n = 0;
    set_req(i, 1'b1, rw, a, d);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_acc[i] && n < 50);
    check($sformatf("accept_seen[%0d]", i), m_acc[i], 1'b1);
    t_acc[i]    = cyc - 1;
    last_err[i] = out_err(i);
    set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_ack(input int i, output line_t rd, output int lat);
    int n;
    n = 0;
    while (out_ack(i) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ack_seen[%0d]", i), out_ack(i), 1'b1);
    rd  = out_data(i);
    lat = cyc - t_acc[i];
  endtask

  task automatic finish_ack(input int i);
    set_ack_rdy(i, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int i, input logic rw, input logic [31:0] a, input line_t d,
                      output line_t rd, output int lat);
    issue(i, rw, a, d);
    wait_ack(i, rd, lat);
    finish_ack(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    line_t rd, pinc, p0, p2, p3, pb, pn;
    int    lat;

    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_ack_rdy(0, 1'b1);
    set_ack_rdy(1, 1'b1);

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rdy_during_reset", bus_a.req_rdy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rdy_a", bus_a.req_rdy, 1'b1);
    check("idle_ack_a", bus_a.ack_valid, 1'b0);
    check("idle_err_a", err_a, 1'b0);
    check("idle_rdy_b", bus_b.req_rdy, 1'b1);

    // Write then read, LATENCY=4
    for (int b = 0; b < 32; b++) pinc[8*b +: 8] = 8'(b);
    xfer(0, 1'b0, BASE + 32'h40, pinc, rd, lat);
    check("wr_latency_5", lat, 5);
    xfer(0, 1'b1, BASE + 32'h40, ~pinc, rd, lat);
    check("rd_latency_5", lat, 5);
    check("rd_bytes_literal", rd,
          256'h1F1E1D1C1B1A19181716151413121110_0F0E0D0C0B0A09080706050403020100);

    // Backpressure
    p2 = mkpat(32'hA5A5_0000);
    xfer(0, 1'b0, BASE + 32'hA0, p2, rd, lat);
    set_ack_rdy(0, 1'b0);
    issue(0, 1'b1, BASE + 32'hA0, '0);
    wait_ack(0, rd, lat);
    check("bp_first_data", rd, p2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid_held", bus_a.ack_valid, 1'b1);
      check("bp_data_held", bus_a.ack_rd_data, p2);
      check("bp_rdy_low", bus_a.req_rdy, 1'b0);
    end
    set_ack_rdy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_rdy", bus_a.req_rdy, 1'b1);
    check("bp_release_valid", bus_a.ack_valid, 1'b0);
    check("bp_release_data", bus_a.ack_rd_data, '0);

    // LATENCY=0, last line, misaligned read
    p3 = mkpat(32'h3C3C_1000);
    xfer(1, 1'b0, BASE + 32'h7FE0, p3, rd, lat);
    check("l0_wr_latency_1", lat, 1);
    xfer(1, 1'b1, BASE + 32'h7FFF, ~p3, rd, lat);
    check("l0_rd_latency_1", lat, 1);
    check("l0_last_line_data", rd, p3);

    // Out of range
    p0 = mkpat(32'h0BAD_0000);
    xfer(0, 1'b0, BASE, p0, rd, lat);
    check("inrange_no_err", last_err[0], 1'b0);
    pb = mkpat(32'hDEAD_0000);
    xfer(0, 1'b0, BASE + 32'h8000, pb, rd, lat);
    check("oor_wr_err", last_err[0], 1'b1);
    check("oor_wr_latency", lat, 5);
    xfer(0, 1'b1, BASE, '0, rd, lat);
    check("oor_wr_no_alias", rd, p0);
    xfer(0, 1'b1, BASE - 32'h20, '1, rd, lat);
    check("oor_rd_zero", rd, '0);
    check("oor_rd_err", last_err[0], 1'b1);

    // Reset mid-write, counter at 2
    pn = mkpat(32'h7777_0000);
    issue(0, 1'b0, BASE + 32'hA0, pn);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ack_low", bus_a.ack_valid, 1'b0);
    check("abort_rdy_low", bus_a.req_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_rdy", bus_a.req_rdy, 1'b1);
    xfer(0, 1'b1, BASE + 32'hA0, '0, rd, lat);
    check("abort_keeps_old", rd, p2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
